// File: rtl/isqrt_iter_if.sv
// Valid-only operand/result bundle for the iterative square-root engine.
interface isqrt_iter_if;
   logic        x_vld;
   logic [31:0] x;
   logic        y_vld;
   logic [15:0] y;
   logic        busy;
   logic        x_drop;

   modport master (output x_vld, x, input y_vld, y, busy, x_drop);
   modport slave  (input x_vld, x, output y_vld, y, busy, x_drop);
endinterface

// File: rtl/isqrt_iter.sv
// Restoring digit-by-digit integer square root, floor(sqrt(x)) of a 32-bit radicand,
// ITER_PER_CLK root bits per clock, fixed latency, one operation in flight.
module isqrt_iter #(
   parameter int unsigned ITER_PER_CLK = 1
) (
   input  logic         clk,
   input  logic         rst,
   isqrt_iter_if.slave  bus
);

   localparam int unsigned LATENCY  = 16 / ITER_PER_CLK;
   localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 2);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [17:0] rem_q, rem_d;
   logic [15:0] root_q, root_d;
   logic [31:0] rad_q, rad_d;
   logic [15:0] y_q, y_d;
   logic        x_drop_q, x_drop_d;
   logic        accept;
   logic [65:0] step_run;
   logic [65:0] step_new;

   // ITER_PER_CLK restoring iterations; returns {rem, root, remaining radicand}.
   function automatic logic [65:0] unroll(input logic [17:0] rem_in,
                                          input logic [15:0] root_in,
                                          input logic [31:0] rad_in);
      logic [17:0] rem;
      logic [15:0] root;
      logic [31:0] rad;
      logic [17:0] trial;
      rem  = rem_in;
      root = root_in;
      rad  = rad_in;
      for (int unsigned i = 0; i < ITER_PER_CLK; i++) begin
         rem   = {rem[15:0], rad[31:30]};
         rad   = {rad[29:0], 2'b00};
         trial = {root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[14:0], 1'b1};
         end else begin
            root = {root[14:0], 1'b0};
         end
      end
      return {rem, root, rad};
   endfunction

   // The accept edge already performs the first ITER_PER_CLK iterations, so
   // LATENCY-1 RUN clocks complete all 16 and the result lands in DONE.
   assign step_new = unroll('0, '0, bus.x);
   assign step_run = unroll(rem_q, root_q, rad_q);
   assign accept   = bus.x_vld && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      root_d   = root_q;
      rad_d    = rad_q;
      y_d      = y_q;
      x_drop_d = 1'b0;
      case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN: begin
            x_drop_d               = bus.x_vld;
            {rem_d, root_d, rad_d} = step_run;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               y_d     = step_run[47:32];
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE:    state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         cnt_d                  = '0;
         {rem_d, root_d, rad_d} = step_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         rad_q    <= '0;
         y_q      <= '0;
         x_drop_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         rad_q    <= rad_d;
         y_q      <= y_d;
         x_drop_q <= x_drop_d;
      end
   end

   assign bus.y_vld  = (state_q == DONE);
   assign bus.y      = y_q;
   assign bus.busy   = (state_q == RUN);
   assign bus.x_drop = x_drop_q;

endmodule

// File: tb/tb_isqrt_iter.sv
// Bench for isqrt_iter: directed corners/handshake scenarios on the 1-bit/clk engine,
// randomized back-to-back traffic on all three unroll factors against a floor(sqrt) model.
module tb_isqrt_iter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   isqrt_iter_if b1 ();
   isqrt_iter_if b2 ();
   isqrt_iter_if b4 ();

   isqrt_iter #(.ITER_PER_CLK(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   isqrt_iter #(.ITER_PER_CLK(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   isqrt_iter #(.ITER_PER_CLK(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   int unsigned errors = 0;
   int unsigned checks = 0;

   function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
      longint r;
      r = longint'($floor($sqrt(real'(v))));
      while (r * r > longint'(v)) r--;
      while ((r + 1) * (r + 1) <= longint'(v)) r++;
      return 16'(r);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({b1.y_vld, b1.y, b1.busy, b1.x_drop} !== 19'd0) begin
         errors++; $display("FAIL reset_dut1 got=%h want=0", {b1.y_vld, b1.y, b1.busy, b1.x_drop});
      end
      checks++;
      if ({b2.y_vld, b2.y, b2.busy, b2.x_drop} !== 19'd0) begin
         errors++; $display("FAIL reset_dut2 got=%h want=0", {b2.y_vld, b2.y, b2.busy, b2.x_drop});
      end
      checks++;
      if ({b4.y_vld, b4.y, b4.busy, b4.x_drop} !== 19'd0) begin
         errors++; $display("FAIL reset_dut4 got=%h want=0", {b4.y_vld, b4.y, b4.busy, b4.x_drop});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_corners;
      logic [31:0] xs [7] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
      logic [15:0] ys [7] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'hFFFF, 16'hFFFF, 16'hFFFE};
      for (int i = 0; i < 7; i++) begin
         int          lat;
         int          nvld;
         logic [15:0] got_y;
         bit          busy_bad;
         bit          drop_seen;
         lat = -1; nvld = 0; got_y = '0; busy_bad = 0; drop_seen = 0;
         b1.x_vld = 1'b1;
         b1.x     = xs[i];
         for (int c = 1; c <= 20; c++) begin
            tick();
            b1.x_vld = 1'b0;
            b1.x     = $urandom;
            if (b1.y_vld) begin
               nvld++;
               if (lat < 0) begin lat = c; got_y = b1.y; end
            end
            if (b1.busy !== (c < 16)) busy_bad = 1;
            if (b1.x_drop) drop_seen = 1;
         end
         checks++;
         if (lat != 16 || nvld != 1) begin
            errors++; $display("FAIL corner_latency x=%h got=%0d (count %0d) want=16 (count 1)", xs[i], lat, nvld);
         end
         checks++;
         if (got_y !== ys[i]) begin
            errors++; $display("FAIL corner_value x=%h got=%h want=%h", xs[i], got_y, ys[i]);
         end
         checks++;
         if (b1.y !== ys[i]) begin
            errors++; $display("FAIL corner_hold x=%h got=%h want=%h", xs[i], b1.y, ys[i]);
         end
         checks++;
         if (busy_bad || drop_seen) begin
            errors++; $display("FAIL corner_busy x=%h busy_bad=%0d drop=%0d want 0/0", xs[i], busy_bad, drop_seen);
         end
      end
   endtask

   task automatic test_back_to_back;
      int  nvld;
      bit  drop_seen;
      bit  ok16;
      bit  ok32;
      nvld = 0; drop_seen = 0; ok16 = 0; ok32 = 0;
      b1.x_vld = 1'b1;
      b1.x     = 32'd100;
      for (int c = 1; c <= 36; c++) begin
         tick();
         b1.x_vld = 1'b0;
         if (b1.y_vld) nvld++;
         if (b1.x_drop) drop_seen = 1;
         if (c == 16) begin
            ok16     = b1.y_vld && (b1.y === 16'd10);
            b1.x_vld = 1'b1;
            b1.x     = 32'd144;
         end
         if (c == 32) ok32 = b1.y_vld && (b1.y === 16'd12);
      end
      checks++;
      if (!ok16) begin errors++; $display("FAIL b2b_first got=%0d want=1 (y=10 at T+16)", ok16); end
      checks++;
      if (!ok32) begin errors++; $display("FAIL b2b_second got=%0d want=1 (y=12 at T+32)", ok32); end
      checks++;
      if (nvld != 2 || drop_seen) begin
         errors++; $display("FAIL b2b_extra vld=%0d drop=%0d want 2/0", nvld, drop_seen);
      end
   endtask

   task automatic test_drop;
      int          ndrop;
      int          drop_cyc;
      int          nvld;
      int          vld_cyc;
      logic [15:0] got_y;
      ndrop = 0; drop_cyc = -1; nvld = 0; vld_cyc = -1; got_y = '0;
      b1.x_vld = 1'b1;
      b1.x     = 32'd49;
      for (int c = 1; c <= 40; c++) begin
         tick();
         b1.x_vld = 1'b0;
         if (b1.x_drop) begin ndrop++; drop_cyc = c; end
         if (b1.y_vld) begin nvld++; vld_cyc = c; got_y = b1.y; end
         if (c == 5) begin
            b1.x_vld = 1'b1;
            b1.x     = 32'd81;
         end
      end
      checks++;
      if (ndrop != 1 || drop_cyc != 6) begin
         errors++; $display("FAIL drop_pulse got=%0d@%0d want=1@6", ndrop, drop_cyc);
      end
      checks++;
      if (nvld != 1 || vld_cyc != 16) begin
         errors++; $display("FAIL drop_vld got=%0d@%0d want=1@16", nvld, vld_cyc);
      end
      checks++;
      if (got_y !== 16'd7) begin errors++; $display("FAIL drop_value got=%0d want=7", got_y); end
   endtask

   task automatic test_reset_mid;
      bit          bad;
      int          lat;
      logic [15:0] got_y;
      bad = 0; lat = -1; got_y = '0;
      b1.x_vld = 1'b1;
      b1.x     = 32'd1_000_000;
      for (int c = 1; c <= 40; c++) begin
         tick();
         b1.x_vld = 1'b0;
         if (c >= 9 && {b1.y_vld, b1.y, b1.busy, b1.x_drop} !== 19'd0) bad = 1;
         if (c == 8) rst = 1'b1;
         if (c == 11) rst = 1'b0;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL rstmid_outputs got=nonzero want=reset values T+9..T+40"); end
      b1.x_vld = 1'b1;
      b1.x     = 32'd9;
      for (int c = 1; c <= 20; c++) begin
         tick();
         b1.x_vld = 1'b0;
         if (b1.y_vld && lat < 0) begin lat = c; got_y = b1.y; end
      end
      checks++;
      if (lat != 16 || got_y !== 16'd3) begin
         errors++; $display("FAIL rstmid_recover got=%0d@%0d want=3@16", got_y, lat);
      end
   endtask

   task automatic test_random;
      localparam int NW = 1500;
      int          lat [3] = '{16, 8, 4};
      logic [15:0] exp_y [3];
      bit          have [3];
      have = '{0, 0, 0};
      exp_y = '{16'd0, 16'd0, 16'd0};
      for (int w = 0; w <= NW; w++) begin
         for (int c = 0; c < 16; c++) begin
            if (w == NW && c > 0) break;
            for (int k = 0; k < 3; k++) begin
               logic        ov;
               logic [15:0] oy;
               logic        od;
               logic        ev;
               logic [31:0] nx;
               case (k)
                  0:       begin ov = b1.y_vld; oy = b1.y; od = b1.x_drop; end
                  1:       begin ov = b2.y_vld; oy = b2.y; od = b2.x_drop; end
                  default: begin ov = b4.y_vld; oy = b4.y; od = b4.x_drop; end
               endcase
               ev = have[k] && (c % lat[k] == 0);
               checks++;
               if (ov !== ev || od !== 1'b0) begin
                  errors++; $display("FAIL rand_vld ipc_idx=%0d w=%0d c=%0d got=%b/%b want=%b/0", k, w, c, ov, od, ev);
               end
               if (ev) begin
                  checks++;
                  if (oy !== exp_y[k]) begin
                     errors++; $display("FAIL rand_value ipc_idx=%0d w=%0d got=%h want=%h", k, w, oy, exp_y[k]);
                  end
               end
               if (c % lat[k] == 0 && w < NW) begin
                  nx       = $urandom >> $urandom_range(0, 31);
                  exp_y[k] = ref_sqrt(nx);
                  have[k]  = 1;
                  case (k)
                     0:       begin b1.x_vld = 1'b1; b1.x = nx; end
                     1:       begin b2.x_vld = 1'b1; b2.x = nx; end
                     default: begin b4.x_vld = 1'b1; b4.x = nx; end
                  endcase
               end
            end
            tick();
            b1.x_vld = 1'b0; b2.x_vld = 1'b0; b4.x_vld = 1'b0;
            b1.x = $urandom; b2.x = $urandom; b4.x = $urandom;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      b1.x_vld = 1'b0; b1.x = '0;
      b2.x_vld = 1'b0; b2.x = '0;
      b4.x_vld = 1'b0; b4.x = '0;
      test_reset();
      test_corners();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
